imm_decode_stage: RTL and testbench

Parametrised, pipelined successor to the combinational immediate-source decoder. Accepts a raw RV32/RV64 instruction word over a valid/ready handshake. Classifies the format, produces the ImmSrc code, the fully sign/zero-extended XLEN immediate and an illegal-opcode flag through PIPE_DEPTH elastic register stages. Keeps a saturating illegal-instruction counter. Sits between instruction fetch and the register-read/execute stage.

---
 rtl/imm_decode_stage.sv | 152 +++++++++++++++
 tb/tb_imm_decode_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Pipelined immediate decoder: classifies an RV32/RV64 instruction word,
// builds the extended immediate and pushes the result through PIPE_DEPTH
// elastic register stages. Also counts accepted illegal instructions.
module imm_decode_stage #(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       imm_src,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    output logic [6:0]       opcode,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clear
);

    typedef struct packed {
        logic [2:0]      src;
        logic [XLEN-1:0] imm;
        logic            illegal;
        logic [6:0]      opcode;
    } result_t;

    localparam result_t RESULT_RST = '{src: 3'b111, imm: '0, illegal: 1'b0, opcode: 7'd0};

    // Raw immediate fields, signed so that a size cast sign-extends them.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    result_t                 dec;
    result_t                 stage_q [PIPE_DEPTH];
    result_t                 up_d    [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0]   stage_v;
    logic [PIPE_DEPTH-1:0]   up_v;
    logic [PIPE_DEPTH-1:0]   rdy;
    logic [PIPE_DEPTH-1:0]   dn_rdy;
    logic                    accept;

    // Combinational format decode; anything unrecognised falls back to 111/0.
    always_comb begin
        dec        = RESULT_RST;
        dec.opcode = instr[6:0];
        if (instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (instr[6:0])
                7'b0110111, 7'b0010111: begin
                    dec.src = 3'b100;
                    dec.imm = XLEN'(imm_u);
                end
                7'b1101111: begin
                    dec.src = 3'b011;
                    dec.imm = XLEN'(imm_j);
                end
                7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
                    dec.src = 3'b000;
                    dec.imm = XLEN'(imm_i);
                end
                7'b1100011: begin
                    dec.src = 3'b010;
                    dec.imm = XLEN'(imm_b);
                end
                7'b0100011: begin
                    dec.src = 3'b001;
                    dec.imm = XLEN'(imm_s);
                end
                7'b1110011: begin
                    if (instr[14:12] != 3'b000) begin
                        dec.src = 3'b101;
                        dec.imm = XLEN'(instr[19:15]);
                    end
                end
                7'b0110011: dec.illegal = 1'b0;
                default:    dec.illegal = 1'b1;
            endcase
        end
    end

    // Ready chain from the output backwards, plus upstream valid/data per stage.
    always_comb begin
        logic r;
        r = out_ready;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            dn_rdy[i] = r;
            r         = !stage_v[i] || r;
            rdy[i]    = r;
        end
        up_v[0] = in_valid;
        up_d[0] = dec;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            up_v[i] = stage_v[i-1];
            up_d[i] = stage_q[i-1];
        end
    end

    // Elastic stage registers: load when upstream offers and we are ready,
    // otherwise drop valid once the downstream side has taken the contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_v <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= RESULT_RST;
            end
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (up_v[i] && rdy[i]) begin
                    stage_v[i] <= 1'b1;
                    stage_q[i] <= up_d[i];
                end else if (dn_rdy[i]) begin
                    stage_v[i] <= 1'b0;
                end
            end
        end
    end

    assign accept = in_valid && in_ready;

    // Saturating illegal counter, counted at accept time; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= '0;
        end else if (accept && dec.illegal && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = stage_v[PIPE_DEPTH-1];
    assign imm_src   = stage_q[PIPE_DEPTH-1].src;
    assign imm       = stage_q[PIPE_DEPTH-1].imm;
    assign illegal   = stage_q[PIPE_DEPTH-1].illegal;
    assign opcode    = stage_q[PIPE_DEPTH-1].opcode;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit single-stage instance with a
// 2-bit counter, and a 64-bit two-stage instance with an 8-bit counter.
module tb_imm_decode_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int applied     = 0;
    int miscompares = 0;

    // Instance A: XLEN=32, PIPE_DEPTH=1, CNT_W=2
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal, a_err_clear;
    logic [31:0] a_instr, a_imm;
    logic [2:0]  a_imm_src;
    logic [6:0]  a_opcode;
    logic [1:0]  a_err_count;

    // Instance B: XLEN=64, PIPE_DEPTH=2, CNT_W=8
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal, b_err_clear;
    logic [31:0] b_instr;
    logic [63:0] b_imm;
    logic [2:0]  b_imm_src;
    logic [6:0]  b_opcode;
    logic [7:0]  b_err_count;

    imm_decode_stage #(.XLEN(32), .PIPE_DEPTH(1), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .instr(a_instr), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .imm_src(a_imm_src), .imm(a_imm), .illegal(a_illegal), .opcode(a_opcode),
        .err_count(a_err_count), .err_clear(a_err_clear)
    );

    imm_decode_stage #(.XLEN(64), .PIPE_DEPTH(2), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .instr(b_instr), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .imm_src(b_imm_src), .imm(b_imm), .illegal(b_illegal), .opcode(b_opcode),
        .err_count(b_err_count), .err_clear(b_err_clear)
    );

    // 32-bit decode vectors: instr, imm_src, imm, illegal
    logic [31:0] v32_instr [11] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7,
                                    32'h008000EF, 32'h3402D073, 32'h00000073, 32'h002081B3,
                                    32'h0000007F, 32'hFFFFF097, 32'hFFF00090};
    logic [2:0]  v32_src   [11] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101,
                                    3'b111, 3'b111, 3'b111, 3'b100, 3'b111};
    logic [31:0] v32_imm   [11] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000,
                                    32'h00000008, 32'h00000005, 32'h00000000, 32'h00000000,
                                    32'h00000000, 32'hFFFFF000, 32'h00000000};
    logic        v32_ill   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b0, 1'b1};

    // 64-bit decode vectors
    logic [31:0] v64_instr [6] = '{32'h800002B7, 32'h3402D073, 32'hFFF00093,
                                   32'hFE000EE3, 32'h0020A423, 32'h123452B7};
    logic [2:0]  v64_src   [6] = '{3'b100, 3'b101, 3'b000, 3'b010, 3'b001, 3'b100};
    logic [63:0] v64_imm   [6] = '{64'hFFFFFFFF80000000, 64'h0000000000000005,
                                   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                   64'h0000000000000008, 64'h0000000012345000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 0; a_instr = '0; a_out_ready = 1; a_err_clear = 0;
        b_in_valid = 0; b_instr = '0; b_out_ready = 1; b_err_clear = 0;
        #12;
        applied += 6;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_a_out_valid: got %b expected 0", a_out_valid); end
        if (a_imm_src !== 3'b111) begin miscompares++; $display("FAIL rst_a_imm_src: got %b expected 111", a_imm_src); end
        if (a_imm !== 32'h0) begin miscompares++; $display("FAIL rst_a_imm: got %h expected 0", a_imm); end
        if (a_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_a_illegal: got %b expected 0", a_illegal); end
        if (a_opcode !== 7'h0) begin miscompares++; $display("FAIL rst_a_opcode: got %h expected 0", a_opcode); end
        if (a_err_count !== 2'd0) begin miscompares++; $display("FAIL rst_a_err_count: got %0d expected 0", a_err_count); end
        applied += 4;
        if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_b_out_valid: got %b expected 0", b_out_valid); end
        if (b_imm_src !== 3'b111) begin miscompares++; $display("FAIL rst_b_imm_src: got %b expected 111", b_imm_src); end
        if (b_imm !== 64'h0) begin miscompares++; $display("FAIL rst_b_imm: got %h expected 0", b_imm); end
        if (b_err_count !== 8'd0) begin miscompares++; $display("FAIL rst_b_err_count: got %0d expected 0", b_err_count); end
        step();
        reset = 1'b0;
        step();
        applied += 2;
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_a_in_ready: got %b expected 1", a_in_ready); end
        if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_b_in_ready: got %b expected 1", b_in_ready); end
    endtask

    task automatic test_decode32();
        a_out_ready = 1;
        for (int k = 0; k < 11; k++) begin
            a_in_valid = 1;
            a_instr = v32_instr[k];
            step();
            applied += 5;
            if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL d32_valid[%0d]: got %b expected 1", k, a_out_valid); end
            if (a_imm_src !== v32_src[k]) begin miscompares++; $display("FAIL d32_src[%0d]: got %b expected %b", k, a_imm_src, v32_src[k]); end
            if (a_imm !== v32_imm[k]) begin miscompares++; $display("FAIL d32_imm[%0d]: got %h expected %h", k, a_imm, v32_imm[k]); end
            if (a_illegal !== v32_ill[k]) begin miscompares++; $display("FAIL d32_illegal[%0d]: got %b expected %b", k, a_illegal, v32_ill[k]); end
            if (a_opcode !== v32_instr[k][6:0]) begin miscompares++; $display("FAIL d32_opcode[%0d]: got %h expected %h", k, a_opcode, v32_instr[k][6:0]); end
        end
        a_in_valid = 0;
        step();
        applied++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL d32_drain: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_decode64();
        b_out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            b_in_valid = 1;
            b_instr = v64_instr[k];
            step();
            b_in_valid = 0;
            applied++;
            if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL d64_early[%0d]: got %b expected 0", k, b_out_valid); end
            step();
            applied += 4;
            if (b_out_valid !== 1'b1) begin miscompares++; $display("FAIL d64_valid[%0d]: got %b expected 1", k, b_out_valid); end
            if (b_imm_src !== v64_src[k]) begin miscompares++; $display("FAIL d64_src[%0d]: got %b expected %b", k, b_imm_src, v64_src[k]); end
            if (b_imm !== v64_imm[k]) begin miscompares++; $display("FAIL d64_imm[%0d]: got %h expected %h", k, b_imm, v64_imm[k]); end
            if (b_illegal !== 1'b0) begin miscompares++; $display("FAIL d64_illegal[%0d]: got %b expected 0", k, b_illegal); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [11:0] i12 [8];
        logic [63:0] exp_imm [8];
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ins;
        logic [63:0] held;
        logic        stalled;
        int sent, recv, c;
        for (int k = 0; k < 8; k++) begin
            i12[k] = k[0] ? (12'h800 + 12'(k)) : 12'(k + 1);
            exp_imm[k] = {{52{i12[k][11]}}, i12[k]};
        end
        sent = 0; recv = 0; c = 0; stalled = 0; held = '0;
        b_out_ready = pat[0];
        b_in_valid = 1;
        b_instr = {i12[0], 5'd2, 3'b000, 5'd1, 7'b0010011};
        while (recv < 8 && c < 60) begin
            @(negedge clk);
            if (stalled) begin
                applied += 2;
                if (b_out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_valid: got %b expected 1 (cycle %0d)", b_out_valid, c); end
                if (b_imm !== held) begin miscompares++; $display("FAIL b2b_stall_hold: got %h expected %h", b_imm, held); end
            end
            if (recv > 0) begin
                applied++;
                if (b_out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_gap: got out_valid %b expected 1 (cycle %0d)", b_out_valid, c); end
            end
            if (b_out_valid && b_out_ready) begin
                applied++;
                if (b_imm !== exp_imm[recv]) begin miscompares++; $display("FAIL b2b_order[%0d]: got %h expected %h", recv, b_imm, exp_imm[recv]); end
                recv++;
            end
            stalled = b_out_valid && !b_out_ready;
            held = b_imm;
            if (b_in_valid && b_in_ready) sent++;
            step();
            c++;
            b_out_ready = pat[c % 4];
            b_in_valid = (sent < 8);
            ins = {i12[sent % 8], 5'd2, 3'b000, 5'd1, 7'b0010011};
            b_instr = ins;
        end
        applied++;
        if (recv != 8) begin miscompares++; $display("FAIL b2b_count: got %0d results expected 8 within budget", recv); end
        b_in_valid = 0;
        b_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            applied++;
            if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_dup: got out_valid %b expected 0", b_out_valid); end
        end
    endtask

    task automatic test_err_count();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1'b1;
        step();
        reset = 1'b0;
        applied++;
        if (a_err_count !== 2'd0) begin miscompares++; $display("FAIL err_reset: got %0d expected 0", a_err_count); end
        a_out_ready = 1;
        a_instr = 32'h00000000;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1;
            step();
            applied += 4;
            if (a_err_count !== exp_cnt[k]) begin miscompares++; $display("FAIL err_count[%0d]: got %0d expected %0d", k, a_err_count, exp_cnt[k]); end
            if (a_illegal !== 1'b1) begin miscompares++; $display("FAIL err_illegal[%0d]: got %b expected 1", k, a_illegal); end
            if (a_imm !== 32'h0) begin miscompares++; $display("FAIL err_imm[%0d]: got %h expected 0", k, a_imm); end
            if (a_imm_src !== 3'b111) begin miscompares++; $display("FAIL err_src[%0d]: got %b expected 111", k, a_imm_src); end
        end
        a_err_clear = 1;
        step();
        a_err_clear = 0;
        applied++;
        if (a_err_count !== 2'd0) begin miscompares++; $display("FAIL err_clear_wins: got %0d expected 0", a_err_count); end
        step();
        applied++;
        if (a_err_count !== 2'd1) begin miscompares++; $display("FAIL err_after_clear: got %0d expected 1", a_err_count); end
        a_instr = 32'hFFF00093;
        step();
        a_in_valid = 0;
        applied++;
        if (a_err_count !== 2'd1) begin miscompares++; $display("FAIL err_legal_hold: got %0d expected 1", a_err_count); end
        step();
    endtask

    task automatic test_reset_inflight();
        b_out_ready = 0;
        b_instr = 32'h0000007F;
        b_in_valid = 1;
        step();
        step();
        b_in_valid = 0;
        applied += 2;
        if (b_out_valid !== 1'b1) begin miscompares++; $display("FAIL rif_full: got %b expected 1", b_out_valid); end
        if (b_err_count !== 8'd2) begin miscompares++; $display("FAIL rif_count: got %0d expected 2", b_err_count); end
        #2;
        reset = 1'b1;
        #1;
        applied += 3;
        if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL rif_async_valid: got %b expected 0", b_out_valid); end
        if (b_err_count !== 8'd0) begin miscompares++; $display("FAIL rif_async_count: got %0d expected 0", b_err_count); end
        if (b_imm_src !== 3'b111) begin miscompares++; $display("FAIL rif_async_src: got %b expected 111", b_imm_src); end
        step();
        step();
        reset = 1'b0;
        b_out_ready = 1;
        applied++;
        if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL rif_in_ready: got %b expected 1", b_in_ready); end
        for (int k = 0; k < 6; k++) begin
            step();
            applied++;
            if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL rif_ghost[%0d]: got %b expected 0", k, b_out_valid); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode32();
        test_decode64();
        test_back_to_back();
        test_err_count();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
